waterfall_fb_ctrl: RTL

//  Owns the single-port 8b waterfall frame buffer and sequences all accesses to it.

---
 rtl/waterfall_fb_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/waterfall_fb_ctrl.sv
// -----------------------------------------------------------------------------
// waterfall_fb_ctrl
//
// Owns the single-port 8-bit waterfall frame buffer and decides, every clock,
// who drives it:
//   * CLEAR      : after reset or clear request, zero-fills every location.
//   * VIDEO      : per-pixel readout address with a circular row offset, so the
//                  oldest line appears at the top of the screen.
//   * LINE       : once every SCROLL_DIV vertical blanks, copies LINE_BINS
//                  bins from the freq-bin BRAM into the oldest row, then
//                  advances the row offset.
//   * WAIT_BLANK : parked until the current blanking period ends.
//
// Ports
//   clk_i          pixel clock
//   rst_i          asynchronous, active-high reset
//   x_i / y_i      video column / row
//   lower_blank_i  high during vertical blanking
//   clear_req_i    pulse: re-clear the frame buffer, y_offset back to 0
//   bin_rdata_i    freq-bin BRAM read data (1 clk after bin_ren_o/bin_addr_o)
//   bin_addr_o     freq-bin BRAM read address
//   bin_ren_o      freq-bin BRAM read enable
//   fb_addr_o      frame buffer address (registered)
//   fb_wdata_o     frame buffer write data
//   fb_wen_o       frame buffer write enable
//   y_offset_o     frame buffer row shown at the top of the screen
//   scroll_pulse_o 1-clk pulse when a line copy completes
//   busy_o         high while clearing or copying a line
//   overrun_o      sticky: blanking ended before a line copy finished
// -----------------------------------------------------------------------------
module waterfall_fb_ctrl #(
    parameter int H_VISIBLE  = 320,
    parameter int V_VISIBLE  = 240,
    parameter int LINE_BINS  = 320,
    parameter int SCROLL_DIV = 4,
    parameter int FB_ADDR_W  = 17,
    parameter int BIN_ADDR_W = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [8:0]            x_i,
    input  logic [7:0]            y_i,
    input  logic                  lower_blank_i,
    input  logic                  clear_req_i,
    input  logic [7:0]            bin_rdata_i,
    output logic [BIN_ADDR_W-1:0] bin_addr_o,
    output logic                  bin_ren_o,
    output logic [FB_ADDR_W-1:0]  fb_addr_o,
    output logic [7:0]            fb_wdata_o,
    output logic                  fb_wen_o,
    output logic [7:0]            y_offset_o,
    output logic                  scroll_pulse_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int CLR_W = FB_ADDR_W + 1;
    localparam int RD_W  = BIN_ADDR_W + 1;
    localparam int FC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [CLR_W-1:0]     FB_WORDS_C  = CLR_W'(H_VISIBLE * V_VISIBLE);
    localparam logic [RD_W-1:0]      LINE_BINS_C = RD_W'(LINE_BINS);
    localparam logic [FB_ADDR_W-1:0] H_C         = FB_ADDR_W'(H_VISIBLE);
    localparam logic [8:0]           V_C         = 9'(V_VISIBLE);
    localparam logic [7:0]           V_LAST_C    = 8'(V_VISIBLE - 1);
    localparam logic [FC_W-1:0]      FC_LAST_C   = FC_W'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_WAIT_BLANK,
        ST_VIDEO,
        ST_LINE
    } state_t;

    state_t                 state_q, state_d;
    logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic [RD_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic                   clear_pend_q, clear_pend_d;
    logic [7:0]             y_offset_q, y_offset_d;
    logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic                   fb_wen_q, fb_wen_d;
    logic                   wr_bin_q, wr_bin_d;
    logic [BIN_ADDR_W-1:0]  bin_addr_q, bin_addr_d;
    logic                   bin_ren_q, bin_ren_d;
    logic                   scroll_pulse_q, scroll_pulse_d;
    logic                   overrun_q, overrun_d;

    // Display row: (y + y_offset) mod V, summed in 9 bits so 239+239 cannot wrap.
    logic [8:0]             row_sum;
    logic [8:0]             row_idx;
    logic [FB_ADDR_W-1:0]   video_addr;
    logic [FB_ADDR_W-1:0]   line_addr;
    logic                   take_clear;

    always_comb begin
        row_sum    = {1'b0, y_i} + {1'b0, y_offset_q};
        row_idx    = (row_sum >= V_C) ? (row_sum - V_C) : row_sum;
        video_addr = FB_ADDR_W'(x_i) + FB_ADDR_W'(row_idx) * H_C;
        // The read issued last cycle (bin_addr_q) lands in the oldest row.
        line_addr  = FB_ADDR_W'(bin_addr_q) + FB_ADDR_W'(y_offset_q) * H_C;
        // A request arriving this very cycle counts, so it beats a scroll decision.
        take_clear = clear_pend_q | clear_req_i;
    end

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        clear_pend_d   = clear_pend_q | clear_req_i;
        y_offset_d     = y_offset_q;
        fb_addr_d      = fb_addr_q;
        fb_wen_d       = 1'b0;
        wr_bin_d       = 1'b0;
        bin_addr_d     = bin_addr_q;
        bin_ren_d      = 1'b0;
        scroll_pulse_d = 1'b0;
        overrun_d      = overrun_q;

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q < FB_WORDS_C) begin
                    fb_wen_d  = 1'b1;
                    fb_addr_d = clr_cnt_q[FB_ADDR_W-1:0];
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end else begin
                    y_offset_d = 8'd0;
                    state_d    = ST_WAIT_BLANK;
                end
            end

            ST_WAIT_BLANK: begin
                fb_addr_d = video_addr;
                if (take_clear) begin
                    state_d      = ST_CLEAR;
                    clr_cnt_d    = '0;
                    frame_cnt_d  = '0;
                    clear_pend_d = 1'b0;
                end else if (!lower_blank_i) begin
                    state_d = ST_VIDEO;
                end
            end

            ST_VIDEO: begin
                fb_addr_d = video_addr;
                if (take_clear) begin
                    state_d      = ST_CLEAR;
                    clr_cnt_d    = '0;
                    frame_cnt_d  = '0;
                    clear_pend_d = 1'b0;
                end else if (lower_blank_i) begin
                    if (frame_cnt_q == FC_LAST_C) begin
                        frame_cnt_d = '0;
                        rd_cnt_d    = '0;
                        state_d     = ST_LINE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                        state_d     = ST_WAIT_BLANK;
                    end
                end
            end

            ST_LINE: begin
                if (!lower_blank_i) begin
                    overrun_d = 1'b1;
                end
                if (rd_cnt_q < LINE_BINS_C) begin
                    bin_ren_d  = 1'b1;
                    bin_addr_d = rd_cnt_q[BIN_ADDR_W-1:0];
                    rd_cnt_d   = rd_cnt_q + RD_W'(1);
                end
                // Read data comes back one clock after the read, so each write
                // trails its read by exactly one cycle.
                if (bin_ren_q) begin
                    fb_wen_d  = 1'b1;
                    wr_bin_d  = 1'b1;
                    fb_addr_d = line_addr;
                end
                // All reads issued and none in flight: this cycle carries the
                // final write, so the offset advances on the next edge.
                if ((rd_cnt_q == LINE_BINS_C) && !bin_ren_q) begin
                    y_offset_d     = (y_offset_q == V_LAST_C) ? 8'd0 : (y_offset_q + 8'd1);
                    scroll_pulse_d = 1'b1;
                    state_d        = ST_WAIT_BLANK;
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_CLEAR;
            clr_cnt_q      <= '0;
            rd_cnt_q       <= '0;
            frame_cnt_q    <= '0;
            clear_pend_q   <= 1'b0;
            y_offset_q     <= 8'd0;
            fb_addr_q      <= '0;
            fb_wen_q       <= 1'b0;
            wr_bin_q       <= 1'b0;
            bin_addr_q     <= '0;
            bin_ren_q      <= 1'b0;
            scroll_pulse_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            clear_pend_q   <= clear_pend_d;
            y_offset_q     <= y_offset_d;
            fb_addr_q      <= fb_addr_d;
            fb_wen_q       <= fb_wen_d;
            wr_bin_q       <= wr_bin_d;
            bin_addr_q     <= bin_addr_d;
            bin_ren_q      <= bin_ren_d;
            scroll_pulse_q <= scroll_pulse_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bin_addr_o     = bin_addr_q;
    assign bin_ren_o      = bin_ren_q;
    assign fb_addr_o      = fb_addr_q;
    // Clear writes carry zero; line writes pass the BRAM data straight through.
    assign fb_wdata_o     = wr_bin_q ? bin_rdata_i : 8'd0;
    assign fb_wen_o       = fb_wen_q;
    assign y_offset_o     = y_offset_q;
    assign scroll_pulse_o = scroll_pulse_q;
    assign busy_o         = (state_q == ST_CLEAR) || (state_q == ST_LINE);
    assign overrun_o      = overrun_q;

endmodule
